// File: rtl/intd_pkg.sv
// Shared types for the interrupt dispatcher: FSM state encoding and cause codes.
package intd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DISPATCH = 2'b01,
    ST_KERNEL   = 2'b10,
    ST_RETURN   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_SYS  = 2'b01,
    CAUSE_TMR  = 2'b10,
    CAUSE_OP   = 2'b11
  } cause_t;

endpackage

// File: rtl/intd_arbiter.sv
// Fixed-priority pick among pending interrupt causes (SYS > TIMER > OP)
// and mux of the winning cause's vector.
module intd_arbiter
  import intd_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              sys_pend,
  input  logic              tmr_pend,
  input  logic              op_pend,
  input  logic [ADDR_W-1:0] sys_vec,
  input  logic [ADDR_W-1:0] tmr_vec,
  input  logic [ADDR_W-1:0] op_vec,
  output logic              any_pend,
  output cause_t            cause,
  output logic [ADDR_W-1:0] vec
);

  // Highest-priority pending cause wins; vector follows the winner.
  always_comb begin
    any_pend = sys_pend | tmr_pend | op_pend;
    cause    = CAUSE_NONE;
    vec      = '0;
    if (sys_pend) begin
      cause = CAUSE_SYS;
      vec   = sys_vec;
    end else if (tmr_pend) begin
      cause = CAUSE_TMR;
      vec   = tmr_vec;
    end else if (op_pend) begin
      cause = CAUSE_OP;
      vec   = op_vec;
    end
  end

endmodule

// File: rtl/interrupt_dispatcher.sv
// CPU-side interrupt dispatcher: latches scheduler/decoder requests, waits for
// an instruction boundary, saves the PC to epc, jumps to the cause's vector in
// kernel mode, and returns to epc on IRET.
// Optional macro INTD_COUNT_EN adds saturating per-cause dispatch counters.
module interrupt_dispatcher
  import intd_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              init_flag,
  input  logic              timer_int,
  input  logic              op_int,
  input  logic              sys_req,
  input  logic [ADDR_W-1:0] int_pos,
  input  logic [ADDR_W-1:0] op_int_pos,
  input  logic [ADDR_W-1:0] sys_int_pos,
  input  logic              PRG_ENB,
  input  logic [ADDR_W-1:0] PC_pos,
  input  logic              IRET_flag,
  output logic              PC_load,
  output logic [ADDR_W-1:0] PC_load_value,
  output logic              kernel_mode,
  output logic              int_ack,
  output logic [1:0]        int_cause,
  output logic [ADDR_W-1:0] epc
`ifdef INTD_COUNT_EN
  ,
  output logic [CNT_W-1:0]  cnt_sys,
  output logic [CNT_W-1:0]  cnt_tmr,
  output logic [CNT_W-1:0]  cnt_op
`endif
);

  state_t            state, state_nxt;
  cause_t            cause_q;
  logic [ADDR_W-1:0] tgt_q;
  logic              sys_pend, tmr_pend, op_pend;
  logic              timer_q;
  logic              any_pend;
  cause_t            win_cause;
  logic [ADDR_W-1:0] win_vec;
  logic              capture, drop;
  logic              clr_sys, clr_tmr, clr_op;
  logic              tmr_rise;

  intd_arbiter #(.ADDR_W(ADDR_W)) u_arb (
    .sys_pend (sys_pend),
    .tmr_pend (tmr_pend),
    .op_pend  (op_pend),
    .sys_vec  (sys_int_pos),
    .tmr_vec  (int_pos),
    .op_vec   (op_int_pos),
    .any_pend (any_pend),
    .cause    (win_cause),
    .vec      (win_vec)
  );

  assign tmr_rise  = timer_int & ~timer_q;
  assign int_cause = cause_q;

  // Only the arbitration winner is cleared, whether dispatched or dropped.
  assign clr_sys = (capture | drop) && (win_cause == CAUSE_SYS);
  assign clr_tmr = (capture | drop) && (win_cause == CAUSE_TMR);
  assign clr_op  = (capture | drop) && (win_cause == CAUSE_OP);

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!init_flag) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Next-state and strobe outputs.
  always_comb begin
    state_nxt     = state;
    PC_load       = 1'b0;
    PC_load_value = '0;
    int_ack       = 1'b0;
    capture       = 1'b0;
    drop          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_pend && PRG_ENB) begin
          if (win_vec == '0) begin
            drop = 1'b1;
          end else begin
            capture   = 1'b1;
            state_nxt = ST_DISPATCH;
          end
        end
      end
      ST_DISPATCH: begin
        PC_load       = 1'b1;
        PC_load_value = tgt_q;
        int_ack       = 1'b1;
        state_nxt     = ST_KERNEL;
      end
      ST_KERNEL: begin
        if (IRET_flag) state_nxt = ST_RETURN;
      end
      ST_RETURN: begin
        PC_load       = 1'b1;
        PC_load_value = epc;
        state_nxt     = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pending latches; a new request in the capture cycle outlives the clear.
  always_ff @(posedge clock) begin
    if (!init_flag) begin
      sys_pend <= 1'b0;
      tmr_pend <= 1'b0;
      op_pend  <= 1'b0;
      timer_q  <= 1'b0;
    end else begin
      sys_pend <= (sys_pend & ~clr_sys) | sys_req;
      tmr_pend <= (tmr_pend & ~clr_tmr) | tmr_rise;
      op_pend  <= (op_pend  & ~clr_op)  | op_int;
      timer_q  <= timer_int;
    end
  end

  // Capture context on dispatch; kernel_mode spans DISPATCH and KERNEL.
  always_ff @(posedge clock) begin
    if (!init_flag) begin
      epc         <= '0;
      cause_q     <= CAUSE_NONE;
      tgt_q       <= '0;
      kernel_mode <= 1'b0;
    end else begin
      if (capture) begin
        epc         <= PC_pos;
        cause_q     <= win_cause;
        tgt_q       <= win_vec;
        kernel_mode <= 1'b1;
      end else if ((state == ST_KERNEL) && IRET_flag) begin
        kernel_mode <= 1'b0;
      end
    end
  end

`ifdef INTD_COUNT_EN
  // Saturating per-cause dispatch counters, bumped in the DISPATCH cycle.
  always_ff @(posedge clock) begin
    if (!init_flag) begin
      cnt_sys <= '0;
      cnt_tmr <= '0;
      cnt_op  <= '0;
    end else if (state == ST_DISPATCH) begin
      case (cause_q)
        CAUSE_SYS: if (cnt_sys != '1) cnt_sys <= cnt_sys + CNT_W'(1);
        CAUSE_TMR: if (cnt_tmr != '1) cnt_tmr <= cnt_tmr + CNT_W'(1);
        CAUSE_OP:  if (cnt_op  != '1) cnt_op  <= cnt_op  + CNT_W'(1);
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// Scoreboard bench for interrupt_dispatcher: stimulus pushes the expected
// PC_load events, a negedge monitor pops and compares each one.
module tb_interrupt_dispatcher;

  localparam int AW = 16;
`ifdef INTD_COUNT_EN
  localparam int CW = 2;
`endif

  logic          clock = 1'b0;
  logic          init_flag, timer_int, op_int, sys_req, PRG_ENB, IRET_flag;
  logic [AW-1:0] int_pos, op_int_pos, sys_int_pos, PC_pos;
  logic          PC_load, kernel_mode, int_ack;
  logic [AW-1:0] PC_load_value, epc;
  logic [1:0]    int_cause;
`ifdef INTD_COUNT_EN
  logic [CW-1:0] cnt_sys, cnt_tmr, cnt_op;
`endif

  int checks    = 0;
  int errors    = 0;
  int ack_count = 0;
  int exp_acks  = 0;

  typedef struct {
    logic [AW-1:0] val;
    logic          ack;
    logic [1:0]    cause;
    logic [AW-1:0] epc;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  interrupt_dispatcher #(
    .ADDR_W(AW)
`ifdef INTD_COUNT_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clock         (clock),
    .init_flag     (init_flag),
    .timer_int     (timer_int),
    .op_int        (op_int),
    .sys_req       (sys_req),
    .int_pos       (int_pos),
    .op_int_pos    (op_int_pos),
    .sys_int_pos   (sys_int_pos),
    .PRG_ENB       (PRG_ENB),
    .PC_pos        (PC_pos),
    .IRET_flag     (IRET_flag),
    .PC_load       (PC_load),
    .PC_load_value (PC_load_value),
    .kernel_mode   (kernel_mode),
    .int_ack       (int_ack),
    .int_cause     (int_cause),
    .epc           (epc)
`ifdef INTD_COUNT_EN
    ,
    .cnt_sys       (cnt_sys),
    .cnt_tmr       (cnt_tmr),
    .cnt_op        (cnt_op)
`endif
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endfunction

  // Monitor: every PC_load / int_ack event must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (init_flag === 1'b1 && (PC_load === 1'b1 || int_ack === 1'b1)) begin
      if (int_ack === 1'b1) ack_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: PC_load=%0b value=%h int_ack=%0b, required no event",
                 PC_load, PC_load_value, int_ack);
      end else begin
        e = sb.pop_front();
        chk("pc_load", 32'(PC_load), 32'd1);
        chk("pc_load_value", 32'(PC_load_value), 32'(e.val));
        chk("int_ack", 32'(int_ack), 32'(e.ack));
        chk("int_cause", 32'(int_cause), 32'(e.cause));
        chk("epc", 32'(epc), 32'(e.epc));
        if (e.ack) chk("kernel_mode_dispatch", 32'(kernel_mode), 32'd1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] val, input logic ack,
                      input logic [1:0] cause, input logic [AW-1:0] pc);
    exp_t e;
    e.val = val; e.ack = ack; e.cause = cause; e.epc = pc;
    sb.push_back(e);
    if (ack) exp_acks++;
  endtask

  // Instruction boundary expected to dispatch (vec, cause) with epc = pc.
  task automatic dispatch(input logic [AW-1:0] pc, input logic [AW-1:0] vec,
                          input logic [1:0] cause);
    push(vec, 1'b1, cause, pc);
    PRG_ENB = 1'b1; PC_pos = pc;
    tick(1);
    PRG_ENB = 1'b0;
    tick(3);
  endtask

  // Instruction boundary expected to cause nothing.
  task automatic prg_only(input logic [AW-1:0] pc);
    PRG_ENB = 1'b1; PC_pos = pc;
    tick(1);
    PRG_ENB = 1'b0;
    tick(3);
  endtask

  task automatic iret(input logic [AW-1:0] pc, input logic [1:0] cause);
    push(pc, 1'b0, cause, pc);
    IRET_flag = 1'b1;
    tick(1);
    IRET_flag = 1'b0;
    tick(2);
  endtask

  task automatic sys_pulse();
    sys_req = 1'b1; tick(1); sys_req = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_pc_load"}, 32'(PC_load), 32'd0);
    chk({tag, "_pc_load_value"}, 32'(PC_load_value), 32'd0);
    chk({tag, "_kernel_mode"}, 32'(kernel_mode), 32'd0);
    chk({tag, "_int_ack"}, 32'(int_ack), 32'd0);
    chk({tag, "_int_cause"}, 32'(int_cause), 32'd0);
    chk({tag, "_epc"}, 32'(epc), 32'd0);
  endtask

  task automatic do_reset();
    init_flag = 1'b0;
    tick(2);
    init_flag = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    init_flag = 1'b0; timer_int = 1'b0; op_int = 1'b0; sys_req = 1'b0;
    PRG_ENB = 1'b0; IRET_flag = 1'b0; PC_pos = '0;
    int_pos = 16'h0100; op_int_pos = 16'h0300; sys_int_pos = 16'h0200;
    tick(3);
    check_idle_zero("reset");
    init_flag = 1'b1;
    tick(1);

`ifdef INTD_COUNT_EN
    // Five SYS dispatches saturate a 2-bit counter at 3.
    for (int i = 0; i < 5; i++) begin
      sys_pulse();
      dispatch(16'h0010 + 16'(i), 16'h0200, 2'b01);
      iret(16'h0010 + 16'(i), 2'b01);
    end
    chk("cnt_sys_saturated", 32'(cnt_sys), 32'd3);
    chk("cnt_tmr_zero", 32'(cnt_tmr), 32'd0);
    chk("cnt_op_zero", 32'(cnt_op), 32'd0);
    do_reset();
    chk("cnt_sys_reset", 32'(cnt_sys), 32'd0);
    tick(1);
`endif

    // Timer request, held high across dispatch and IRET: one dispatch only.
    timer_int = 1'b1;
    tick(1);
    dispatch(16'h0042, 16'h0100, 2'b10);
    iret(16'h0042, 2'b10);
    chk("kernel_after_return", 32'(kernel_mode), 32'd0);
    prg_only(16'h0044);
    timer_int = 1'b0; tick(1);
    timer_int = 1'b1; tick(1);
    dispatch(16'h0050, 16'h0100, 2'b10);
    iret(16'h0050, 2'b10);
    timer_int = 1'b0;
    tick(1);

    // Simultaneous SYS and OP: SYS first, OP at the next boundary.
    sys_req = 1'b1; op_int = 1'b1;
    tick(1);
    sys_req = 1'b0; op_int = 1'b0;
    dispatch(16'h0060, 16'h0200, 2'b01);
    iret(16'h0060, 2'b01);
    dispatch(16'h0070, 16'h0300, 2'b11);
    iret(16'h0070, 2'b11);

    // IRET outside KERNEL is ignored.
    IRET_flag = 1'b1; tick(1); IRET_flag = 1'b0; tick(2);

    // OP request arriving in the SYS capture cycle stays pending.
    sys_pulse();
    push(16'h0200, 1'b1, 2'b01, 16'h0078);
    PRG_ENB = 1'b1; PC_pos = 16'h0078; op_int = 1'b1;
    tick(1);
    PRG_ENB = 1'b0; op_int = 1'b0;
    tick(3);
    iret(16'h0078, 2'b01);
    dispatch(16'h007a, 16'h0300, 2'b11);
    iret(16'h007a, 2'b11);

    // Unconfigured OP vector: dropped, pend cleared, no mode change.
    op_int_pos = '0;
    op_int = 1'b1; tick(1); op_int = 1'b0;
    prg_only(16'h0080);
    chk("drop_kernel_mode", 32'(kernel_mode), 32'd0);
    chk("drop_cause_held", 32'(int_cause), 32'd3);
    chk("drop_epc_held", 32'(epc), 32'h007a);
    op_int_pos = 16'h0300;
    prg_only(16'h0082);

    // Reset while in KERNEL with a timer request pending.
    timer_int = 1'b1; tick(1);
    dispatch(16'h0090, 16'h0100, 2'b10);
    timer_int = 1'b0; tick(1);
    timer_int = 1'b1; tick(1);
    timer_int = 1'b0; tick(1);
    chk("kernel_before_reset", 32'(kernel_mode), 32'd1);
    init_flag = 1'b0;
    tick(1);
    init_flag = 1'b1;
    check_idle_zero("midreset");
    prg_only(16'h0094);
    chk("midreset_kernel_stays", 32'(kernel_mode), 32'd0);

    tick(5);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("int_ack_count", 32'(ack_count), 32'(exp_acks));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
